// File: rtl/counter_run_ctrl_if.sv
// Key inputs and counter/LED status outputs of the lab-board run controller.
// The master side drives the raw keys; the slave side is the controller.
interface counter_run_ctrl_if #(
  parameter int unsigned CNT_W = 4
) ();

  logic [3:0]       key_n;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] led_n;
  logic [1:0]       state;
  logic             dir_down;
  logic             tick;
  logic             wrap;

  modport master (
    output key_n,
    input  cnt,
    input  led_n,
    input  state,
    input  dir_down,
    input  tick,
    input  wrap
  );

  modport slave (
    input  key_n,
    output cnt,
    output led_n,
    output state,
    output dir_down,
    output tick,
    output wrap
  );

endinterface

// File: rtl/counter_run_ctrl.sv
// Key-driven IDLE/RUN/PAUSE controller for a prescaled up/down counter:
// synchronises and debounces four active-low keys, sequences the counter, drives LEDs.
module counter_run_ctrl #(
  parameter int unsigned CNT_W           = 4,
  parameter int unsigned PRESCALE        = 25000000,
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input logic               clk,
  input logic               reset,
  counter_run_ctrl_if.slave bus
);

  localparam int unsigned NumKeys = 4;
  // Debounce counter only has to reach DEBOUNCE_CYCLES-1; the final sample flips the level.
  localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned PsW = $clog2(PRESCALE);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [PsW-1:0] PsLast = PsW'(PRESCALE - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StPause = 2'd2;

  localparam int unsigned KeyStart = 0;
  localparam int unsigned KeyDir   = 1;
  localparam int unsigned KeyStep  = 2;
  localparam int unsigned KeyClear = 3;

  // ---------------------------------------------------------------------------
  // Key input path: 2-flop synchroniser, debounce, press-event detection
  // ---------------------------------------------------------------------------
  logic [NumKeys-1:0] sync1_q;
  logic [NumKeys-1:0] sync2_q;
  logic [NumKeys-1:0] level_q;
  logic [NumKeys-1:0] level_d;
  logic [NumKeys-1:0] press_q;
  logic [NumKeys-1:0] press_d;
  logic [DbW-1:0]     db_cnt_q [NumKeys];
  logic [DbW-1:0]     db_cnt_d [NumKeys];

  always_comb begin
    for (int i = 0; i < NumKeys; i++) begin
      level_d[i]  = level_q[i];
      press_d[i]  = 1'b0;
      db_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (db_cnt_q[i] == DbLast) begin
          level_d[i] = sync2_q[i];
          press_d[i] = ~sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '1;
      sync2_q <= '1;
      level_q <= '1;
      press_q <= '0;
      for (int i = 0; i < NumKeys; i++) begin
        db_cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= bus.key_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      for (int i = 0; i < NumKeys; i++) begin
        db_cnt_q[i] <= db_cnt_d[i];
      end
    end
  end

  logic start_ev;
  logic dir_ev;
  logic step_ev;
  logic clear_ev;

  assign start_ev = press_q[KeyStart];
  assign dir_ev   = press_q[KeyDir];
  assign step_ev  = press_q[KeyStep];
  assign clear_ev = press_q[KeyClear];

  // ---------------------------------------------------------------------------
  // Run FSM, prescaler and counter
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PsW-1:0]   presc_q;
  logic [PsW-1:0]   presc_d;
  logic             dir_down_q;
  logic             dir_down_d;
  logic             wrap_q;
  logic             wrap_d;
  logic             tick;
  logic             do_step;
  logic             at_edge;

  assign tick = (state_q == StRun) && (presc_q == PsLast);

  always_comb begin
    state_d = state_q;
    do_step = 1'b0;
    if (clear_ev) begin
      state_d = StIdle;
    end else begin
      // A start press drops a same-cycle step press, but never a prescaler tick.
      do_step = tick | (step_ev & ~start_ev & (state_q != StRun));
      if (start_ev) begin
        case (state_q)
          StIdle:  state_d = StRun;
          StRun:   state_d = StPause;
          StPause: state_d = StRun;
          default: state_d = StIdle;
        endcase
      end
    end
  end

  // Direction used for a step is the registered one, before any same-cycle toggle.
  assign at_edge = dir_down_q ? (cnt_q == '0) : (cnt_q == '1);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_ev) begin
      cnt_d = '0;
    end else if (do_step) begin
      cnt_d = dir_down_q ? (cnt_q - CNT_W'(1)) : (cnt_q + CNT_W'(1));
    end
  end

  assign wrap_d     = do_step & at_edge;
  assign dir_down_d = dir_down_q ^ dir_ev;

  // Prescaler only runs while staying in RUN, so every RUN entry starts a full period.
  always_comb begin
    presc_d = '0;
    if ((state_q == StRun) && (state_d == StRun) && !tick) begin
      presc_d = presc_q + PsW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      presc_q    <= '0;
      dir_down_q <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      presc_q    <= presc_d;
      dir_down_q <= dir_down_d;
      wrap_q     <= wrap_d;
    end
  end

  assign bus.cnt      = cnt_q;
  assign bus.led_n    = ~cnt_q;
  assign bus.state    = state_q;
  assign bus.dir_down = dir_down_q;
  assign bus.tick     = tick;
  assign bus.wrap     = wrap_q;

endmodule
